dcache_assoc: RTL

Parametrised N-way set-associative, write-back, write-allocate data cache for the pipelined CPU's MEM stage. It sits between the MEM-stage load/store port and the 256-bit-line data memory interface, and uses the same request/stall and enable/ack conventions as the existing direct-mapped cache. It adds configurable associativity and set count, true-LRU replacement, and hit/miss counters.

---
 rtl/dcache_assoc.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back, write-allocate data cache with true-LRU
// replacement and saturating hit/miss counters.
module dcache_assoc #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [255:0]      mem_data_i,
    input  logic              mem_ack_i,
    output logic [255:0]      mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);
    localparam int IW    = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 5 - IW;
    localparam int AW    = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
    state_t state, state_n;

    logic              valid [SETS][WAYS];
    logic              dirty [SETS][WAYS];
    logic [AW-1:0]     age   [SETS][WAYS];
    logic [TAG_W-1:0]  tag   [SETS][WAYS];
    logic [255:0]      data  [SETS][WAYS];

    logic [IW-1:0]     idx;
    logic [TAG_W-1:0]  rtag;
    logic [2:0]        word;
    logic [AW-1:0]     vic, vic_n, hit_way;
    logic [ADDR_W-1:0] line_addr;
    logic              req, hit, idle_hit, idle_miss, replay, unused_ok;

    assign idx       = p1_addr_i[5+IW-1:5];
    assign rtag      = p1_addr_i[ADDR_W-1:5+IW];
    assign word      = p1_addr_i[4:2];
    assign unused_ok = ^p1_addr_i[1:0];
    assign req       = p1_MemRead_i | p1_MemWrite_i;
    assign idle_hit  = state == IDLE && req && hit;
    assign idle_miss = state == IDLE && req && !hit;

    // Victim: lowest-index invalid way wins over the oldest way, so it is assigned last.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_n   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag[idx][w] == rtag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (age[idx][w] == AW'(WAYS - 1)) vic_n = AW'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[idx][w]) vic_n = AW'(w);
    end

    always_comb begin
        state_n = state;
        if (idle_miss)
            state_n = (valid[idx][vic_n] && dirty[idx][vic_n]) ? WRITEBACK : REFILL;
        else if (state == WRITEBACK && mem_ack_i)
            state_n = REFILL;
        else if (state == REFILL && mem_ack_i)
            state_n = IDLE;
    end

    assign line_addr    = state == WRITEBACK ? {tag[idx][vic], idx, 5'b0} :
                          state == REFILL    ? {rtag, idx, 5'b0} : '0;
    assign mem_addr_o   = 32'(line_addr);
    assign mem_enable_o = state != IDLE;
    assign mem_write_o  = state == WRITEBACK;
    assign mem_data_o   = data[idx][vic];
    assign p1_data_o    = data[idx][hit_way][{word, 5'b0} +: 32];
    assign p1_stall_o   = state != IDLE || idle_miss;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            vic        <= '0;
            replay     <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    age[s][w]   <= AW'(w);
                end
        end else begin
            state <= state_n;
            if (idle_miss) begin
                vic <= vic_n;
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1;
            end
            if (idle_hit) begin
                replay <= 1'b0;
                if (!replay && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1;
                if (p1_MemWrite_i) dirty[idx][hit_way] <= 1'b1;
                for (int w = 0; w < WAYS; w++)
                    if (AW'(w) == hit_way) age[idx][w] <= '0;
                    else if (age[idx][w] < age[idx][hit_way]) age[idx][w] <= age[idx][w] + 1;
            end
            if (state == REFILL && mem_ack_i) begin
                valid[idx][vic] <= 1'b1;
                dirty[idx][vic] <= 1'b0;
                replay          <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == REFILL && mem_ack_i) begin
            data[idx][vic] <= mem_data_i;
            tag[idx][vic]  <= rtag;
        end
        if (idle_hit && p1_MemWrite_i) data[idx][hit_way][{word, 5'b0} +: 32] <= p1_data_i;
    end
endmodule
